// File: rtl/mult_pkg.sv
// Shared types and widths for the round-robin multiplier scheduler.
package mult_pkg;

    localparam int unsigned OPERAND_W = 4;
    localparam int unsigned PRODUCT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        HOLD
    } sched_state_t;

endpackage

// File: rtl/mult_core.sv
// Combinational unsigned multiplier; full-width product, no truncation.
module mult_core
    import mult_pkg::*;
(
    input  logic [OPERAND_W-1:0] i_a,
    input  logic [OPERAND_W-1:0] i_b,
    output logic [PRODUCT_W-1:0] o_p
);

    assign o_p = PRODUCT_W'(i_a) * PRODUCT_W'(i_b);

endmodule

// File: rtl/rr_arb.sv
// Combinational round-robin picker: search starts one past i_last_grant and wraps.
module rr_arb #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_last_grant,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_grant_idx,
    output logic             o_any_req
);

    logic [ID_W-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_req   = 1'b0;
        w_idx       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_idx = ID_W'((32'(i_last_grant) + 32'd1 + k) % N_REQ);
            if (!o_any_req && i_req[w_idx]) begin
                o_any_req   = 1'b1;
                o_grant_idx = w_idx;
            end
        end
        if (o_any_req) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one 4x4 multiplier among N_REQ requesters; round-robin accept, registered
// response with requester ID on a single valid/ready channel.
module mult_rr_scheduler
    import mult_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [OPERAND_W*N_REQ-1:0]   req_a,
    input  logic [OPERAND_W*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         rsp_valid,
    output logic [PRODUCT_W-1:0]         rsp_prod,
    output logic [ID_W-1:0]              rsp_id,
    input  logic                         rsp_ready,
    output logic                         busy
);

    sched_state_t         r_state;
    sched_state_t         w_state_next;
    logic [OPERAND_W-1:0] r_op_a;
    logic [OPERAND_W-1:0] r_op_b;
    logic [ID_W-1:0]      r_op_id;
    logic [ID_W-1:0]      r_last_grant;
    logic                 r_rsp_valid;
    logic [PRODUCT_W-1:0] r_rsp_prod;
    logic [ID_W-1:0]      r_rsp_id;
    logic                 r_busy;

    logic [N_REQ-1:0]     w_grant;
    logic [ID_W-1:0]      w_grant_idx;
    logic                 w_any_req;
    logic                 w_can_accept;
    logic                 w_accept;
    logic [OPERAND_W-1:0] w_sel_a;
    logic [OPERAND_W-1:0] w_sel_b;
    logic [PRODUCT_W-1:0] w_prod;

    rr_arb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arb (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_any_req    (w_any_req)
    );

    mult_core u_mult_core (
        .i_a (r_op_a),
        .i_b (r_op_b),
        .o_p (w_prod)
    );

    // rst_n gating keeps req_ready low for the whole reset window
    assign w_can_accept = rst_n && ((r_state == IDLE) || ((r_state == HOLD) && rsp_ready));
    assign w_accept     = w_can_accept && w_any_req;
    assign req_ready    = w_can_accept ? w_grant : '0;

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (w_grant[k]) begin
                w_sel_a = req_a[k*OPERAND_W +: OPERAND_W];
                w_sel_b = req_b[k*OPERAND_W +: OPERAND_W];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_next = CALC;
            CALC:    w_state_next = HOLD;
            HOLD:    if (rsp_ready) w_state_next = w_accept ? CALC : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_id      <= '0;
            r_last_grant <= ID_W'(N_REQ - 1);
            r_rsp_valid  <= 1'b0;
            r_rsp_prod   <= '0;
            r_rsp_id     <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != IDLE);
            if (w_accept) begin
                r_op_a       <= w_sel_a;
                r_op_b       <= w_sel_b;
                r_op_id      <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end
            if (r_state == CALC) begin
                r_rsp_valid <= 1'b1;
                r_rsp_prod  <= w_prod;
                r_rsp_id    <= r_op_id;
            end else if ((r_state == HOLD) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_prod  = r_rsp_prod;
    assign rsp_id    = r_rsp_id;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Self-checking bench for mult_rr_scheduler: vector table plus directed corner sequences.
module tb_mult_rr_scheduler;

    localparam int unsigned N = 4;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [4*N-1:0] req_a;
    logic [4*N-1:0] req_b;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic [7:0]    rsp_prod;
    logic [1:0]    rsp_id;
    logic          rsp_ready;
    logic          busy;

    int n_vec;
    int n_miss;

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] prod;
    } vec_t;

    vec_t vecs[8];

    mult_rr_scheduler #(
        .N_REQ (N),
        .ID_W  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_prod  (rsp_prod),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic next_neg();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at a falling edge with the DUT idle; single requester, rsp_ready high.
    task automatic run_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] prod);
        req_a[4*idx +: 4] = a;
        req_b[4*idx +: 4] = b;
        req_valid         = '0;
        req_valid[idx]    = 1'b1;
        rsp_ready         = 1'b1;
        #1 chk("tbl_ready", 32'(req_ready), 32'(1 << idx));
        next_neg();
        req_valid = '0;
        #1 chk("tbl_calc_busy", 32'(busy), 32'd1);
        chk("tbl_calc_nvalid", 32'(rsp_valid), 32'd0);
        next_neg();
        #1 chk("tbl_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tbl_rsp_prod", 32'(rsp_prod), 32'(prod));
        chk("tbl_rsp_id", 32'(rsp_id), 32'(idx));
        next_neg();
        #1 chk("tbl_rsp_drop", 32'(rsp_valid), 32'd0);
        chk("tbl_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int g_exp[3];
        int p_exp[3];
        int i_exp[3];

        vecs[0] = '{2, 4'd7,  4'd9,  8'd63};
        vecs[1] = '{0, 4'd15, 4'd15, 8'd225};
        vecs[2] = '{1, 4'd0,  4'd13, 8'd0};
        vecs[3] = '{3, 4'd1,  4'd1,  8'd1};
        vecs[4] = '{0, 4'd15, 4'd1,  8'd15};
        vecs[5] = '{3, 4'd8,  4'd2,  8'd16};
        vecs[6] = '{1, 4'd5,  4'd5,  8'd25};
        vecs[7] = '{2, 4'd12, 4'd11, 8'd132};

        n_vec     = 0;
        n_miss    = 0;
        clk       = 1'b0;
        rst_n     = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_prod", 32'(rsp_prod), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].prod);
        end

        // Fresh reset so requester 0 leads the round-robin sweep.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a[4*i +: 4] = 4'(i + 1);
            req_b[4*i +: 4] = 4'd3;
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1 chk("rr_first", 32'(req_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            next_neg();
            #1 chk("rr_calc_ready", 32'(req_ready), 32'd0);
            chk("rr_calc_valid", 32'(rsp_valid), 32'd0);
            next_neg();
            #1 chk("rr_valid", 32'(rsp_valid), 32'd1);
            chk("rr_prod", 32'(rsp_prod), 32'((k + 1) * 3));
            chk("rr_id", 32'(rsp_id), 32'(k));
            chk("rr_next_grant", 32'(req_ready), 32'(1 << ((k + 1) % 4)));
        end
        req_valid = '0;
        next_neg();
        #1 chk("rr_idle", 32'(busy), 32'd0);

        // Back-pressure: response held while requester 1 waits.
        req_a[3:0] = 4'd3;
        req_b[3:0] = 4'd4;
        req_valid  = 4'b0001;
        rsp_ready  = 1'b0;
        #1 chk("bp_accept0", 32'(req_ready), 32'd1);
        next_neg();
        req_a[7:4] = 4'd2;
        req_b[7:4] = 4'd6;
        req_valid  = 4'b0010;
        #1 chk("bp_calc_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            #1 chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_prod", 32'(rsp_prod), 32'd12);
            chk("bp_hold_id", 32'(rsp_id), 32'd0);
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(req_ready), 32'b0010);
        next_neg();
        req_valid = '0;
        #1 chk("bp_cleared", 32'(rsp_valid), 32'd0);
        next_neg();
        #1 chk("bp_r1_valid", 32'(rsp_valid), 32'd1);
        chk("bp_r1_prod", 32'(rsp_prod), 32'd12);
        chk("bp_r1_id", 32'(rsp_id), 32'd1);
        next_neg();

        // Asynchronous reset while an operation is in CALC.
        req_a[11:8] = 4'd5;
        req_b[11:8] = 4'd5;
        req_valid   = 4'b0100;
        @(posedge clk);
        #1 chk("ar_busy_calc", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_valid", 32'(rsp_valid), 32'd0);
        chk("ar_prod", 32'(rsp_prod), 32'd0);
        chk("ar_id", 32'(rsp_id), 32'd0);
        chk("ar_ready", 32'(req_ready), 32'd0);
        req_a[3:0]   = 4'd4;
        req_b[3:0]   = 4'd4;
        req_a[15:12] = 4'd2;
        req_b[15:12] = 4'd2;
        req_valid    = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ar_first_grant", 32'(req_ready), 32'd1);
        next_neg();
        #1 chk("ar_no_stale_rsp", 32'(rsp_valid), 32'd0);
        next_neg();
        #1 chk("ar_r0_valid", 32'(rsp_valid), 32'd1);
        chk("ar_r0_prod", 32'(rsp_prod), 32'd16);
        chk("ar_r0_id", 32'(rsp_id), 32'd0);
        chk("ar_next_grant", 32'(req_ready), 32'b1000);
        req_valid = '0;
        next_neg();

        // Pointer wrap: requester 3 alone, then requester 0 joins.
        req_a[15:12] = 4'd6;
        req_b[15:12] = 4'd2;
        req_valid    = 4'b1000;
        #1 chk("wr_first", 32'(req_ready), 32'b1000);
        next_neg();
        req_a[3:0] = 4'd1;
        req_b[3:0] = 4'd9;
        req_valid  = 4'b1001;
        #1 chk("wr_calc_ready", 32'(req_ready), 32'd0);
        g_exp = '{0, 3, 0};
        p_exp = '{12, 9, 12};
        i_exp = '{3, 0, 3};
        for (int k = 0; k < 3; k++) begin
            next_neg();
            #1 chk("wr_valid", 32'(rsp_valid), 32'd1);
            chk("wr_prod", 32'(rsp_prod), 32'(p_exp[k]));
            chk("wr_id", 32'(rsp_id), 32'(i_exp[k]));
            chk("wr_grant", 32'(req_ready), 32'(1 << g_exp[k]));
            next_neg();
            #1 chk("wr_calc_ready", 32'(req_ready), 32'd0);
        end
        req_valid = '0;
        next_neg();
        #1 chk("wr_last_prod", 32'(rsp_prod), 32'd9);
        chk("wr_last_id", 32'(rsp_id), 32'd0);
        next_neg();
        #1 chk("wr_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mult_rr_scheduler.md
# mult_rr_scheduler

Shares one 4x4 unsigned combinational multiplier core among N_REQ requesters. Requesters present operand pairs on valid/ready channels; a round-robin arbiter grants one per accept slot. The scheduler registers operands, captures the 8-bit product and returns it with the requester ID on a single valid/ready response channel. It sits between the multiplier datapath and the blocks that need occasional products, so one multiplier serves the whole cluster.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(N_REQ), width of requester ID

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  N_REQ  per-requester operand valid
- req_a  in  4*N_REQ  operand A, requester i at bits [4i+3:4i]
- req_b  in  4*N_REQ  operand B, same packing
- req_ready  out  N_REQ  one-hot accept; at most one bit high per cycle
- rsp_valid  out  1  product available
- rsp_prod  out  8  unsigned product A*B
- rsp_id  out  ID_W  index of the requester that issued the operation
- rsp_ready  in  1  consumer accepts the response
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states:
  - IDLE: no operation in flight.
  - CALC: operands latched, product computed this cycle.
  - HOLD: response presented.
- Accept window (can_accept): state==IDLE, or state==HOLD && rsp_ready.
- Arbitration:
  - Only valid requesters compete.
  - Search starts at last_grant+1 and wraps modulo N_REQ.
  - First valid requester found wins.
  - req_ready[i] = (winner==i) && can_accept.
  - req_ready depends combinationally on req_valid. Requesters must not derive req_valid from req_ready, and must hold valid and operands stable until accepted.
- Accept (req_valid[i] && req_ready[i]):
  - Latch op_a, op_b and op_id=i.
  - Set last_grant=i.
  - Next state CALC.
- CALC: drive op_a/op_b into the multiplier core, register the result into rsp_prod and op_id into rsp_id, set rsp_valid, go to HOLD. CALC is always exactly one cycle and cannot stall.
- HOLD:
  - rsp_valid held with rsp_prod/rsp_id stable until rsp_ready.
  - On rsp_ready with a new accept in the same cycle: go to CALC, clear rsp_valid.
  - On rsp_ready with no accept: go to IDLE, clear rsp_valid.
- Arithmetic: unsigned 4x4 to 8 bits, no truncation; 15*15=225.
- last_grant updates only on accept. It does not change in CALC, in HOLD without rsp_ready, or while no requester is valid.
- Reset, at any time including mid-CALC or HOLD:
  - Any in-flight operation is discarded with no response.
  - state=IDLE, rsp_valid=0, rsp_prod=0, rsp_id=0, busy=0, req_ready=0 while rst_n low.
  - last_grant=N_REQ-1, so requester 0 has first priority after reset.

## Timing
- Accept at edge T → CALC during cycle T..T+1 → rsp_valid high after edge T+1. Latency is 2 edges from accept to response visible.
- Maximum throughput: one operation per 2 cycles, sustained when rsp_ready is held high and requests are continuous.
- Back-pressure: with rsp_ready low, no further accepts happen, every req_ready stays 0, and the response is held indefinitely.
- Fairness: with all N_REQ continuously valid and rsp_ready=1, grants cycle 0,1,..,N_REQ-1,0. Any valid requester is served within N_REQ accepts.
- rsp_valid, rsp_prod, rsp_id and busy are registered outputs. req_ready is combinational from req_valid, state and rsp_ready.

## Structure
- Shared package mult_pkg holds:
  - OPERAND_W=4 and PRODUCT_W=8;
  - enum sched_state_t {IDLE, CALC, HOLD}.
- Sub-module rr_arb: parameterised N_REQ round-robin priority picker.
  - Inputs: req vector and last_grant.
  - Outputs: one-hot grant, grant index and any_req.
  - Purely combinational; last_grant is held in the scheduler.
- The existing combinational multiplier core is instantiated once and fed from the op_a/op_b registers.

## Test plan
- Reset, then req_valid[2]=1 with a=7, b=9, rsp_ready=1 → req_ready[2] pulses one cycle; 2 edges later rsp_valid=1, rsp_prod=63, rsp_id=2, held one cycle.
- All four requesters valid, each with a=i+1, b=3, rsp_ready=1 → grant order 0,1,2,3; products 3,6,9,12; one response every 2 cycles.
- a=15, b=15 and a=0, b=13 → rsp_prod=225, then 0.
- Response pending and rsp_ready held low for 5 cycles while requester 1 is valid:
  - rsp_prod/rsp_id stable and req_ready all 0 throughout;
  - raising rsp_ready accepts requester 1 in that same cycle.
- rst_n dropped asynchronously in CALC → rsp_valid=0 and busy=0 immediately; after release, requester 0 is granted first over requester 3 when both are valid.
- Requester 3 alone repeatedly valid, then requester 0 joins → grants 3,0,3,0 (pointer wrap verified).
